// File: rtl/cft_bus_pkg.sv
// Shared definitions for the bus cycle monitor: FSM encoding, fault kind
// layout, parameter defaults and a saturating counter helper.
package cft_bus_pkg;

   localparam int          DEF_TIMEOUT  = 64;
   localparam int          DEF_ROM_WS   = 2;
   localparam logic [7:0]  DEF_ROM_PAGE = 8'h00;
   localparam int          TIMER_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INSERT = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_FAULT  = 3'd3,
      ST_DRAIN  = 3'd4
   } bus_state_t;

   // Bit order matches the fault_kind port: {io, write}.
   typedef struct packed {
      logic io;
      logic write;
   } fault_kind_t;

   localparam fault_kind_t FK_NONE = '{io: 1'b0, write: 1'b0};

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts clocks of externally held wait within one bus cycle; tc flags the
// edge on which the count would reach TERMINAL.
module bus_wait_timer #(
   parameter int WIDTH    = 8,
   parameter int TERMINAL = 64
) (
   input  logic clk1,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign tc = en && (count_reg == LAST);

endmodule

// File: rtl/bus_cycle_monitor.sv
// Bus cycle monitor: inserts ROM wait states, times externally held waits,
// latches faults with a halt request and counts bus cycles.
module bus_cycle_monitor
   import cft_bus_pkg::*;
#(
   parameter int         TIMEOUT  = DEF_TIMEOUT,
   parameter int         ROM_WS   = DEF_ROM_WS,
   parameter logic [7:0] ROM_PAGE = DEF_ROM_PAGE
) (
   input  logic        clk1,
   input  logic        reset,
   input  logic        nmem,
   input  logic        nio,
   input  logic        nr,
   input  logic        nw,
   input  logic        nws_in,
   input  logic [23:0] ab,
   input  logic        clr,
   output logic        nws_drv,
   output logic        nhalt_drv,
   output logic        buserr,
   output logic [23:0] fault_ab,
   output logic [1:0]  fault_kind,
   output logic [15:0] ncycles
);

   localparam bit         HAS_WS   = (ROM_WS > 0);
   localparam logic [7:0] INS_LOAD = HAS_WS ? 8'(ROM_WS - 1) : 8'd0;

   bus_state_t  state_reg, state_next;
   logic [7:0]  ins_cnt_reg, ins_cnt_next;
   logic        nws_drv_reg, nhalt_drv_reg, buserr_reg;
   logic [23:0] fault_ab_reg;
   fault_kind_t fault_kind_reg;
   logic [15:0] ncycles_reg;

   logic active, rom_hit, clr_outside;
   logic cycle_start, fault_set, fault_release;
   logic timer_en, timer_clr, timer_tc;

   assign active      = (!nmem || !nio) && (!nr || !nw);
   assign rom_hit     = HAS_WS && !nmem && (ab[23:16] == ROM_PAGE);
   assign clr_outside = clr && (state_reg != ST_FAULT);

   bus_wait_timer #(
      .WIDTH    (TIMER_W),
      .TERMINAL (TIMEOUT)
   ) u_timer (
      .clk1  (clk1),
      .reset (reset),
      .en    (timer_en),
      .clr   (timer_clr),
      .tc    (timer_tc)
   );

   always_comb begin
      state_next    = state_reg;
      ins_cnt_next  = ins_cnt_reg;
      cycle_start   = 1'b0;
      fault_set     = 1'b0;
      fault_release = 1'b0;
      timer_en      = 1'b0;
      timer_clr     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            timer_clr = 1'b1;
            if (active) begin
               cycle_start = 1'b1;
               if (rom_hit) begin
                  state_next   = ST_INSERT;
                  ins_cnt_next = INS_LOAD;
               end else begin
                  state_next = ST_ACTIVE;
               end
            end
         end
         ST_INSERT: begin
            timer_clr = 1'b1;
            if (!active) begin
               state_next = ST_IDLE;
            end else if (ins_cnt_reg == 8'd0) begin
               state_next = ST_ACTIVE;
            end else begin
               ins_cnt_next = ins_cnt_reg - 8'd1;
            end
         end
         ST_ACTIVE: begin
            if (!active) begin
               state_next = ST_IDLE;
               timer_clr  = 1'b1;
            end else begin
               // Only waits held by someone else count toward the timeout.
               timer_en = !nws_in && nws_drv_reg;
               if (timer_tc) begin
                  state_next = ST_FAULT;
                  fault_set  = 1'b1;
               end
            end
         end
         ST_FAULT: begin
            timer_clr = 1'b1;
            if (clr) begin
               fault_release = 1'b1;
               state_next    = active ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            timer_clr = 1'b1;
            if (!active) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            timer_clr  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         ins_cnt_reg <= 8'd0;
         nws_drv_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         ins_cnt_reg <= ins_cnt_next;
         nws_drv_reg <= (state_next != ST_INSERT);
      end
   end

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         buserr_reg     <= 1'b0;
         nhalt_drv_reg  <= 1'b1;
         fault_ab_reg   <= 24'd0;
         fault_kind_reg <= FK_NONE;
      end else begin
         if (fault_set) begin
            buserr_reg    <= 1'b1;
            nhalt_drv_reg <= 1'b0;
         end else if (fault_release || clr_outside) begin
            buserr_reg    <= 1'b0;
            nhalt_drv_reg <= 1'b1;
         end
         if (fault_set) begin
            fault_ab_reg   <= ab;
            fault_kind_reg <= '{io: !nio, write: !nw};
         end else if (clr_outside) begin
            fault_ab_reg   <= 24'd0;
            fault_kind_reg <= FK_NONE;
         end
      end
   end

   // A clear landing on a cycle start still counts that cycle.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         ncycles_reg <= 16'd0;
      end else if (cycle_start) begin
         ncycles_reg <= clr_outside ? 16'd1 : sat_inc16(ncycles_reg);
      end else if (clr_outside) begin
         ncycles_reg <= 16'd0;
      end
   end

   assign nws_drv    = nws_drv_reg;
   assign nhalt_drv  = nhalt_drv_reg;
   assign buserr     = buserr_reg;
   assign fault_ab   = fault_ab_reg;
   assign fault_kind = fault_kind_reg;
   assign ncycles    = ncycles_reg;

endmodule

// File: tb/tb_bus_cycle_monitor.sv
// Self-checking bench for bus_cycle_monitor: per-cycle expectations are queued
// when a bus cycle is launched and compared once the cycle has completed.
module tb_bus_cycle_monitor;

   localparam int         TIMEOUT  = 64;
   localparam int         ROM_WS   = 2;
   localparam logic [7:0] ROM_PAGE = 8'h00;

   logic        clk1 = 1'b0;
   logic        reset;
   logic        nmem, nio, nr, nw, nws_in, clr;
   logic [23:0] ab;
   logic        nws_drv, nhalt_drv, buserr;
   logic [23:0] fault_ab;
   logic [1:0]  fault_kind;
   logic [15:0] ncycles;

   int checks   = 0;
   int failures = 0;
   int exp_ncycles = 0;

   typedef struct {
      int ws;
      int fault_edge;
      int ncyc;
   } exp_t;
   exp_t sb[$];

   bus_cycle_monitor #(
      .TIMEOUT  (TIMEOUT),
      .ROM_WS   (ROM_WS),
      .ROM_PAGE (ROM_PAGE)
   ) dut (
      .clk1       (clk1),
      .reset      (reset),
      .nmem       (nmem),
      .nio        (nio),
      .nr         (nr),
      .nw         (nw),
      .nws_in     (nws_in),
      .ab         (ab),
      .clr        (clr),
      .nws_drv    (nws_drv),
      .nhalt_drv  (nhalt_drv),
      .buserr     (buserr),
      .fault_ab   (fault_ab),
      .fault_kind (fault_kind),
      .ncycles    (ncycles)
   );

   always #5 clk1 = ~clk1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model for one launched cycle; nws_in is seen low on edges 1..low_edges.
   function automatic exp_t model(input logic io, input logic [23:0] addr,
                                  input int low_edges, input int len);
      exp_t e;
      int   ws_full, counted;
      ws_full = (!io && addr[23:16] == ROM_PAGE && ROM_WS > 0) ? ROM_WS : 0;
      e.ws = (len < ws_full) ? len : ws_full;
      counted = low_edges - 1 - ws_full;
      e.fault_edge = (counted >= TIMEOUT && len >= 1 + ws_full + TIMEOUT) ?
                     1 + ws_full + TIMEOUT : 0;
      if (exp_ncycles < 65535) exp_ncycles++;
      e.ncyc = exp_ncycles;
      return e;
   endfunction

   task automatic set_idle();
      nmem = 1'b1; nio = 1'b1; nr = 1'b1; nw = 1'b1; nws_in = 1'b1; clr = 1'b0;
   endtask

   task automatic step();
      @(posedge clk1);
      @(negedge clk1);
   endtask

   // Called at a negedge; drives one cycle for len edges, optionally ending it.
   task automatic do_cycle(input logic io, input logic wr, input logic [23:0] addr,
                           input int low_edges, input int len, input bit drop,
                           output int ws_seen, output int fault_edge);
      ws_seen = 0;
      fault_edge = 0;
      nmem = io; nio = !io; nr = wr; nw = !wr; ab = addr;
      nws_in = (low_edges > 0) ? 1'b0 : 1'b1;
      for (int k = 1; k <= len; k++) begin
         step();
         if (nws_drv === 1'b0) ws_seen++;
         if (buserr === 1'b1 && fault_edge == 0) fault_edge = k;
         if (k >= low_edges) nws_in = 1'b1;
      end
      if (drop) begin
         set_idle();
         step();
      end
   endtask

   task automatic test_reset();
      set_idle();
      ab = 24'h0;
      reset = 1'b1;
      repeat (3) step();
      checks += 6;
      if (nws_drv !== 1'b1)      begin failures++; $display("FAIL reset_nws_drv: got %b expected 1", nws_drv); end
      if (nhalt_drv !== 1'b1)    begin failures++; $display("FAIL reset_nhalt_drv: got %b expected 1", nhalt_drv); end
      if (buserr !== 1'b0)       begin failures++; $display("FAIL reset_buserr: got %b expected 0", buserr); end
      if (fault_ab !== 24'h0)    begin failures++; $display("FAIL reset_fault_ab: got %h expected 000000", fault_ab); end
      if (fault_kind !== 2'b00)  begin failures++; $display("FAIL reset_fault_kind: got %b expected 00", fault_kind); end
      if (ncycles !== 16'h0)     begin failures++; $display("FAIL reset_ncycles: got %h expected 0000", ncycles); end
      reset = 1'b0;
      exp_ncycles = 0;
      step();
   endtask

   task automatic test_cycles();
      logic        t_io[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        t_wr[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [23:0] t_ab[6]   = '{24'h001234, 24'h00ABCD, 24'h120000, 24'h000010, 24'h00F000, 24'h000100};
      int          t_low[6]  = '{0, 0, 0, 0, 10, 0};
      int          t_len[6]  = '{5, 4, 4, 4, 12, 1};
      int ws_seen, fe;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         sb.push_back(model(t_io[i], t_ab[i], t_low[i], t_len[i]));
         do_cycle(t_io[i], t_wr[i], t_ab[i], t_low[i], t_len[i], 1'b1, ws_seen, fe);
         e = sb.pop_front();
         checks += 3;
         if (ws_seen != e.ws) begin failures++; $display("FAIL cycle%0d_wait_states: got %0d expected %0d", i, ws_seen, e.ws); end
         if (fe != e.fault_edge) begin failures++; $display("FAIL cycle%0d_fault_edge: got %0d expected %0d", i, fe, e.fault_edge); end
         if (ncycles !== 16'(e.ncyc)) begin failures++; $display("FAIL cycle%0d_ncycles: got %0d expected %0d", i, ncycles, e.ncyc); end
         $display("cycle %0d ab=%h ws=%0d fault_edge=%0d ncycles=%0d", i, t_ab[i], ws_seen, fe, ncycles);
      end
   endtask

   task automatic test_timeout();
      int ws_seen, fe, bad;
      exp_t e;
      sb.push_back(model(1'b1, 24'h000300, 65, 65));
      do_cycle(1'b1, 1'b1, 24'h000300, 65, 65, 1'b0, ws_seen, fe);
      e = sb.pop_front();
      checks += 7;
      if (fe != e.fault_edge)       begin failures++; $display("FAIL timeout_fault_edge: got %0d expected %0d", fe, e.fault_edge); end
      if (ncycles !== 16'(e.ncyc))  begin failures++; $display("FAIL timeout_ncycles: got %0d expected %0d", ncycles, e.ncyc); end
      if (buserr !== 1'b1)          begin failures++; $display("FAIL timeout_buserr: got %b expected 1", buserr); end
      if (nhalt_drv !== 1'b0)       begin failures++; $display("FAIL timeout_nhalt_drv: got %b expected 0", nhalt_drv); end
      if (fault_ab !== 24'h000300)  begin failures++; $display("FAIL timeout_fault_ab: got %h expected 000300", fault_ab); end
      if (fault_kind !== 2'b11)     begin failures++; $display("FAIL timeout_fault_kind: got %b expected 11", fault_kind); end
      if (ws_seen != e.ws)          begin failures++; $display("FAIL timeout_wait_states: got %0d expected %0d", ws_seen, e.ws); end
      $display("timeout fault_edge=%0d buserr=%b fault_ab=%h kind=%b", fe, buserr, fault_ab, fault_kind);
      // Clear while the cycle is still active: the monitor must drain silently.
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks += 3;
      if (buserr !== 1'b0)          begin failures++; $display("FAIL drain_buserr: got %b expected 0", buserr); end
      if (nhalt_drv !== 1'b1)       begin failures++; $display("FAIL drain_nhalt_drv: got %b expected 1", nhalt_drv); end
      if (fault_ab !== 24'h000300)  begin failures++; $display("FAIL drain_fault_ab: got %h expected 000300", fault_ab); end
      nws_in = 1'b0;
      bad = 0;
      for (int k = 0; k < TIMEOUT + 10; k++) begin
         step();
         if (buserr !== 1'b0 || nws_drv !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL drain_no_counting: got %0d bad clocks expected 0", bad); end
      set_idle();
      step();
      sb.push_back(model(1'b1, 24'h000020, 0, 2));
      do_cycle(1'b1, 1'b0, 24'h000020, 0, 2, 1'b1, ws_seen, fe);
      e = sb.pop_front();
      checks++;
      if (ncycles !== 16'(e.ncyc)) begin failures++; $display("FAIL after_drain_ncycles: got %0d expected %0d", ncycles, e.ncyc); end
      $display("drain complete ncycles=%0d", ncycles);
   endtask

   task automatic test_near_timeout();
      int ws_seen, fe;
      exp_t e;
      sb.push_back(model(1'b1, 24'h000300, 64, 68));
      do_cycle(1'b1, 1'b1, 24'h000300, 64, 68, 1'b1, ws_seen, fe);
      e = sb.pop_front();
      checks += 3;
      if (fe != e.fault_edge)      begin failures++; $display("FAIL near_timeout_fault_edge: got %0d expected %0d", fe, e.fault_edge); end
      if (nhalt_drv !== 1'b1)      begin failures++; $display("FAIL near_timeout_nhalt_drv: got %b expected 1", nhalt_drv); end
      if (ncycles !== 16'(e.ncyc)) begin failures++; $display("FAIL near_timeout_ncycles: got %0d expected %0d", ncycles, e.ncyc); end
      $display("near timeout fault_edge=%0d ncycles=%0d", fe, ncycles);
   endtask

   task automatic test_clear();
      int ws_seen, fe;
      clr = 1'b1;
      step();
      clr = 1'b0;
      exp_ncycles = 0;
      checks += 4;
      if (ncycles !== 16'h0)    begin failures++; $display("FAIL clear_ncycles: got %h expected 0000", ncycles); end
      if (fault_ab !== 24'h0)   begin failures++; $display("FAIL clear_fault_ab: got %h expected 000000", fault_ab); end
      if (fault_kind !== 2'b00) begin failures++; $display("FAIL clear_fault_kind: got %b expected 00", fault_kind); end
      if (buserr !== 1'b0)      begin failures++; $display("FAIL clear_buserr: got %b expected 0", buserr); end
      $display("clear ncycles=%0d fault_ab=%h", ncycles, fault_ab);
      do_cycle(1'b1, 1'b0, 24'h000040, 0, 2, 1'b1, ws_seen, fe);
      // Clear on the same edge as a new cycle start.
      clr = 1'b1;
      nio = 1'b0; nr = 1'b0; ab = 24'h000044;
      step();
      clr = 1'b0;
      exp_ncycles = 1;
      checks++;
      if (ncycles !== 16'd1) begin failures++; $display("FAIL clear_with_start_ncycles: got %0d expected 1", ncycles); end
      $display("clear with start ncycles=%0d", ncycles);
      step();
      set_idle();
      step();
   endtask

   task automatic test_back_to_back();
      int ws_seen = 0;
      exp_t e;
      e.ws = 0; e.fault_edge = 0;
      if (exp_ncycles < 65535) exp_ncycles++;
      e.ncyc = exp_ncycles;
      sb.push_back(e);
      nmem = 1'b0; nio = 1'b1; nr = 1'b0; nw = 1'b1; ab = 24'h120000;
      for (int k = 0; k < 9; k++) begin
         step();
         if (nws_drv === 1'b0) ws_seen++;
         if (k == 2) begin nmem = 1'b1; nio = 1'b0; nr = 1'b1; nw = 1'b0; ab = 24'h000300; end
         if (k == 5) begin nmem = 1'b0; nio = 1'b1; nr = 1'b0; nw = 1'b1; ab = 24'h001234; end
      end
      set_idle();
      step();
      e = sb.pop_front();
      checks += 2;
      if (ncycles !== 16'(e.ncyc)) begin failures++; $display("FAIL back_to_back_ncycles: got %0d expected %0d", ncycles, e.ncyc); end
      if (ws_seen != e.ws)         begin failures++; $display("FAIL back_to_back_wait_states: got %0d expected %0d", ws_seen, e.ws); end
      $display("back to back ncycles=%0d ws=%0d", ncycles, ws_seen);
   endtask

   task automatic test_saturate();
      int ws_seen, fe;
      exp_t e;
      force dut.ncycles_reg = 16'hFFFE;
      #1;
      release dut.ncycles_reg;
      exp_ncycles = 65534;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(model(1'b1, 24'h000050, 0, 2));
         do_cycle(1'b1, 1'b0, 24'h000050, 0, 2, 1'b1, ws_seen, fe);
         e = sb.pop_front();
         checks++;
         if (ncycles !== 16'(e.ncyc)) begin failures++; $display("FAIL saturate%0d_ncycles: got %h expected %h", i, ncycles, 16'(e.ncyc)); end
         $display("saturate %0d ncycles=%h", i, ncycles);
      end
   endtask

   task automatic test_async_reset();
      int ws_seen;
      nmem = 1'b0; nio = 1'b1; nr = 1'b0; nw = 1'b1; ab = 24'h001234; nws_in = 1'b1;
      step();
      checks++;
      if (nws_drv !== 1'b0) begin failures++; $display("FAIL insert_before_reset_nws_drv: got %b expected 0", nws_drv); end
      #2 reset = 1'b1;
      #1;
      checks += 6;
      if (nws_drv !== 1'b1)     begin failures++; $display("FAIL async_reset_nws_drv: got %b expected 1", nws_drv); end
      if (nhalt_drv !== 1'b1)   begin failures++; $display("FAIL async_reset_nhalt_drv: got %b expected 1", nhalt_drv); end
      if (buserr !== 1'b0)      begin failures++; $display("FAIL async_reset_buserr: got %b expected 0", buserr); end
      if (ncycles !== 16'h0)    begin failures++; $display("FAIL async_reset_ncycles: got %h expected 0000", ncycles); end
      if (fault_ab !== 24'h0)   begin failures++; $display("FAIL async_reset_fault_ab: got %h expected 000000", fault_ab); end
      if (fault_kind !== 2'b00) begin failures++; $display("FAIL async_reset_fault_kind: got %b expected 00", fault_kind); end
      $display("async reset nws_drv=%b ncycles=%h", nws_drv, ncycles);
      @(negedge clk1);
      reset = 1'b0;
      exp_ncycles = 0;
      ws_seen = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (nws_drv === 1'b0) ws_seen++;
         if (k == 0) begin
            exp_ncycles = 1;
            checks++;
            if (ncycles !== 16'd1) begin failures++; $display("FAIL restart_ncycles: got %0d expected 1", ncycles); end
         end
      end
      checks++;
      if (ws_seen != ROM_WS) begin failures++; $display("FAIL restart_wait_states: got %0d expected %0d", ws_seen, ROM_WS); end
      $display("restart after reset ncycles=%0d ws=%0d", ncycles, ws_seen);
      set_idle();
      step();
   endtask

   initial begin
      set_idle();
      ab = 24'h0;
      reset = 1'b1;
      @(negedge clk1);
      test_reset();
      test_cycles();
      test_timeout();
      test_near_timeout();
      test_clear();
      test_back_to_back();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
